// File: rtl/mem_arbiter.sv
// Blink memory-bus arbiter: shares ma/roe_n/wrb_n between the Z80 and the LCD
// screen-fetch engine, stretching Z80 cycles via cwait_n when the LCD must win.
module mem_arbiter #(
  parameter int ACC_CYCLES   = 2,
  parameter int LCD_MAX_WAIT = 8
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic [21:0] cpu_ma,
  input  logic        cpu_mreq,
  input  logic        cpu_rd,
  input  logic        lcd_req,
  input  logic [21:0] lcd_addr,
  input  logic [7:0]  mem_di,
  output logic [21:0] ma,
  output logic        roe_n,
  output logic        wrb_n,
  output logic        cwait_n,
  output logic        lcd_gnt,
  output logic [7:0]  lcd_data,
  output logic        lcd_data_vld,
  output logic [1:0]  owner
);

  // LCD handshake: lcd_req is a level held until lcd_gnt pulses; the grant
  // cycle is when lcd_addr has been captured, so the requester may change the
  // address afterwards. lcd_req still high after lcd_gnt is a fresh request.
  // lcd_data_vld pulses once per completed fetch with lcd_data valid.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_LCD  = 2'd2
  } state_t;

  localparam logic [2:0] ACC_LAST   = 3'(ACC_CYCLES - 1);
  localparam logic [7:0] STARVE_MAX = 8'(LCD_MAX_WAIT);
  localparam logic [21:0] MA_IDLE   = 22'h3FFFFF;

  state_t      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic [2:0]  acc_q, acc_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        gnt_q, gnt_d;
  logic        vld_q, vld_d;
  logic        lcd_wins;
  logic        start_lcd;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    data_d    = data_q;
    starve_d  = starve_q;
    gnt_d     = 1'b0;
    vld_d     = 1'b0;
    start_lcd = 1'b0;
    lcd_wins  = lcd_req && (starve_q == STARVE_MAX);

    case (state_q)
      ST_IDLE: begin
        if (cpu_mreq && !lcd_wins) state_d = ST_CPU;
        else if (lcd_req)          start_lcd = 1'b1;
      end
      ST_CPU: begin
        if (!cpu_mreq) begin
          if (lcd_req) start_lcd = 1'b1;
          else         state_d = ST_IDLE;
        end
      end
      ST_LCD: begin
        acc_d = acc_q + 3'd1;
        if (acc_q == ACC_LAST) begin
          data_d  = mem_di;
          vld_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_lcd) begin
      state_d = ST_LCD;
      addr_d  = lcd_addr;
      acc_d   = 3'd0;
      gnt_d   = 1'b1;
    end

    // Starvation only accrues while the LCD is kept off the bus.
    if (start_lcd)
      starve_d = 8'd0;
    else if (lcd_req && state_q != ST_LCD && starve_q != STARVE_MAX)
      starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state_q  <= ST_IDLE;
      starve_q <= 8'd0;
      acc_q    <= 3'd0;
      addr_q   <= MA_IDLE;
      data_q   <= 8'd0;
      gnt_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    ma      = MA_IDLE;
    roe_n   = 1'b1;
    wrb_n   = 1'b1;
    case (state_q)
      ST_CPU: begin
        ma    = cpu_ma;
        roe_n = !(cpu_mreq && cpu_rd);
        wrb_n = !(cpu_mreq && !cpu_rd);
      end
      ST_LCD: begin
        ma    = addr_q;
        roe_n = 1'b0;
      end
      default: ;
    endcase
    // Gated by rin_n so WAIT is released while the arbiter is held in reset.
    cwait_n = !(rin_n && cpu_mreq && state_q != ST_CPU);
  end

  assign lcd_gnt      = gnt_q;
  assign lcd_data     = data_q;
  assign lcd_data_vld = vld_q;
  assign owner        = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by constrained-random
// traffic, all outputs compared each cycle against a bus-ownership model.
module tb_mem_arbiter;

  localparam int ACC  = 2;
  localparam int MAXW = 8;

  logic        mck;
  logic        rin_n;
  logic [21:0] cpu_ma;
  logic        cpu_mreq;
  logic        cpu_rd;
  logic        lcd_req;
  logic [21:0] lcd_addr;
  logic [7:0]  mem_di;
  logic [21:0] ma;
  logic        roe_n;
  logic        wrb_n;
  logic        cwait_n;
  logic        lcd_gnt;
  logic [7:0]  lcd_data;
  logic        lcd_data_vld;
  logic [1:0]  owner;

  mem_arbiter #(.ACC_CYCLES(ACC), .LCD_MAX_WAIT(MAXW)) dut (
    .mck(mck), .rin_n(rin_n), .cpu_ma(cpu_ma), .cpu_mreq(cpu_mreq),
    .cpu_rd(cpu_rd), .lcd_req(lcd_req), .lcd_addr(lcd_addr), .mem_di(mem_di),
    .ma(ma), .roe_n(roe_n), .wrb_n(wrb_n), .cwait_n(cwait_n),
    .lcd_gnt(lcd_gnt), .lcd_data(lcd_data), .lcd_data_vld(lcd_data_vld),
    .owner(owner)
  );

  // Clock
  initial mck = 1'b0;
  always #5 mck = ~mck;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the bus, how many LCD cycles remain, and how
  // long the LCD has been kept waiting.
  int          m_own;
  int          m_left;
  int          m_starve;
  logic [21:0] m_addr;
  logic [7:0]  m_data;
  bit          m_gnt;
  bit          m_vld;
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_left = 0; m_starve = 0;
    m_addr = '0; m_data = '0; m_gnt = 0; m_vld = 0;
  endtask

  task automatic model_edge();
    bit start;
    bit was_lcd;
    if (!rin_n) begin
      model_reset();
      return;
    end
    start   = 0;
    was_lcd = (m_own == 2);
    m_gnt   = 0;
    m_vld   = 0;
    if (m_own == 0) begin
      if (cpu_mreq && !(lcd_req && m_starve == MAXW)) m_own = 1;
      else if (lcd_req) start = 1;
    end else if (m_own == 1) begin
      if (!cpu_mreq) begin
        if (lcd_req) start = 1;
        else m_own = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_data = mem_di;
        m_vld  = 1;
        exp_q.push_back(mem_di);
        m_own  = 0;
      end
    end
    if (start) m_starve = 0;
    else if (lcd_req && !was_lcd) m_starve = (m_starve + 1 > MAXW) ? MAXW : m_starve + 1;
    if (start) begin
      m_own  = 2;
      m_left = ACC;
      m_addr = lcd_addr;
      m_gnt  = 1;
    end
  endtask

  task automatic check_outputs();
    logic [21:0] e_ma;
    logic [7:0]  e_byte;
    e_ma = (m_own == 1) ? cpu_ma : (m_own == 2) ? m_addr : 22'h3FFFFF;
    chk("ma", ma, e_ma);
    chk("roe_n", roe_n, (m_own == 2 || (m_own == 1 && cpu_mreq && cpu_rd)) ? 0 : 1);
    chk("wrb_n", wrb_n, (m_own == 1 && cpu_mreq && !cpu_rd) ? 0 : 1);
    chk("cwait_n", cwait_n, (rin_n && cpu_mreq && m_own != 1) ? 0 : 1);
    chk("owner", owner, m_own);
    chk("lcd_gnt", lcd_gnt, m_gnt);
    chk("lcd_data_vld", lcd_data_vld, m_vld);
    chk("lcd_data", lcd_data, m_data);
    if (m_vld && exp_q.size() > 0) begin
      e_byte = exp_q.pop_front();
      chk("fetched_byte", lcd_data, e_byte);
    end
  endtask

  // Driver tasks
  task automatic sample();
    @(negedge mck);
    check_outputs();
  endtask

  task automatic advance();
    @(posedge mck);
    model_edge();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic quiet();
    cpu_mreq = 0; cpu_rd = 0; lcd_req = 0;
  endtask

  initial begin
    int cpu_hold;
    cpu_hold = 0;

    // Reset held with both requesters active
    rin_n = 0; cpu_ma = 22'h0; cpu_mreq = 1; cpu_rd = 1;
    lcd_req = 1; lcd_addr = 22'h1; mem_di = 8'h00;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_ma", ma, 22'h3FFFFF);
      chk("rst_cwait_n", cwait_n, 1);
      chk("rst_gnt", lcd_gnt, 0);
      advance();
    end
    rin_n = 1; quiet();
    cycles(2);

    // CPU read then write
    for (int w = 0; w < 2; w++) begin
      cpu_mreq = 1; cpu_rd = (w == 0); cpu_ma = 22'h201234;
      sample(); chk("cpu_c1_cwait_n", cwait_n, 0); chk("cpu_c1_owner", owner, 0); advance();
      sample();
      chk("cpu_c2_owner", owner, 1);
      chk("cpu_c2_ma", ma, 22'h201234);
      chk("cpu_c2_roe_n", roe_n, (w == 0) ? 0 : 1);
      chk("cpu_c2_wrb_n", wrb_n, (w == 0) ? 1 : 0);
      chk("cpu_c2_cwait_n", cwait_n, 1);
      advance();
      cycles(1);
      quiet();
      cycles(2);
    end

    // Single LCD fetch
    lcd_req = 1; lcd_addr = 22'h080100; mem_di = 8'hA5;
    cycles(1);
    lcd_req = 0;
    sample();
    chk("lcd_c2_gnt", lcd_gnt, 1); chk("lcd_c2_ma", ma, 22'h080100);
    chk("lcd_c2_roe_n", roe_n, 0); chk("lcd_c2_owner", owner, 2);
    advance();
    sample(); chk("lcd_c3_gnt", lcd_gnt, 0); chk("lcd_c3_ma", ma, 22'h080100); advance();
    sample(); chk("lcd_c4_vld", lcd_data_vld, 1); chk("lcd_c4_data", lcd_data, 8'hA5); advance();
    cycles(1);

    // CPU arrives during the first LCD cycle
    lcd_req = 1; lcd_addr = 22'h0ABCDE; mem_di = 8'h3C;
    cycles(1);
    lcd_req = 0; cpu_mreq = 1; cpu_rd = 1; cpu_ma = 22'h000777;
    sample(); chk("col_lcd1_cwait_n", cwait_n, 0); advance();
    sample(); chk("col_lcd2_cwait_n", cwait_n, 0); advance();
    sample(); chk("col_idle_owner", owner, 0); advance();
    sample(); chk("col_cpu_owner", owner, 1); chk("col_cpu_cwait_n", cwait_n, 1); advance();
    quiet();
    cycles(2);

    // Long CPU tenure with a waiting LCD
    lcd_req = 1; lcd_addr = 22'h123456; cpu_mreq = 1; cpu_rd = 0; cpu_ma = 22'h3F0000;
    cycles(12);
    cpu_mreq = 0;
    cycles(1);
    cpu_mreq = 1;
    cycles(6);
    quiet();
    cycles(4);

    // Saturated starvation: LCD beats the CPU from IDLE
    lcd_req = 1; cpu_mreq = 1; cpu_rd = 1; cpu_ma = 22'h000100; lcd_addr = 22'h2A0000;
    cycles(10);
    lcd_req = 0;
    cycles(1);
    cpu_mreq = 0;
    cycles(1);
    lcd_req = 1; cpu_mreq = 1; mem_di = 8'h5A;
    sample(); chk("starve_idle_cwait_n", cwait_n, 0); chk("starve_idle_owner", owner, 0); advance();
    lcd_req = 0;
    sample(); chk("starve_lcd1_owner", owner, 2); chk("starve_lcd1_cwait_n", cwait_n, 0); advance();
    sample(); chk("starve_lcd2_owner", owner, 2); chk("starve_lcd2_cwait_n", cwait_n, 0); advance();
    cycles(3);
    quiet();
    cycles(2);

    // Reset during the second LCD cycle
    lcd_req = 1; lcd_addr = 22'h055555; mem_di = 8'hEE;
    cycles(1);
    lcd_req = 0;
    cycles(1);
    rin_n = 0;
    model_reset();
    #1;
    chk("arst_owner", owner, 0); chk("arst_ma", ma, 22'h3FFFFF);
    chk("arst_roe_n", roe_n, 1); chk("arst_gnt", lcd_gnt, 0);
    cycles(2);
    rin_n = 1;
    for (int i = 0; i < 4; i++) begin
      sample(); chk("arst_no_vld", lcd_data_vld, 0); advance();
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if (!(lcd_req && !m_gnt)) begin
        lcd_req  = ($urandom_range(0, 2) == 0);
        lcd_addr = 22'($urandom());
      end
      if (cpu_hold > 0) begin
        cpu_hold--;
      end else begin
        cpu_mreq = ($urandom_range(0, 1) == 1);
        cpu_rd   = ($urandom_range(0, 1) == 1);
        cpu_ma   = 22'($urandom());
        cpu_hold = $urandom_range(0, 12);
      end
      mem_di = 8'($urandom());
      if (!rin_n) begin
        rin_n = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        rin_n = 0;
        model_reset();
      end
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
